seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DWELL_CYC, default 12500: clk cycles each digit is driven (>=1).
REQ-002 Parameter GAP_CYC, default 250: clk cycles with all digits off between digits (0 allowed, meaning no gap).
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 load_valid  input  1  new display value offered.
REQ-006 load_data  input  16  four hex nibbles; nibble 0 (bits 3:0) is the rightmost digit.
REQ-007 load_ready  output  1  shadow register empty, so the offer is accepted.
REQ-008 blank_lz  input  1  leading-zero blanking enable, sampled at the frame boundary.
REQ-009 sel  output  4  digit enables, active-low; sel[0] is the rightmost digit.
REQ-010 seg  output  7  segments g..a in bits 6..0, active-low.
REQ-011 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-012 The FSM SHALL have two states, DWELL and GAP, plus a 2-bit digit index (0..3) and a dwell/gap counter sized for the larger parameter.
REQ-013 In DWELL, exactly one sel bit (the indexed digit) SHALL be 0, and seg SHALL carry the decoded nibble of the active register, or 7'h7F if that digit is blanked.
REQ-014 In GAP, sel SHALL be 4'hF and seg SHALL be 7'h7F.
REQ-015 DWELL SHALL last exactly DWELL_CYC cycles, then go to GAP; if GAP_CYC=0, it SHALL go directly to DWELL of the next digit.
REQ-016 GAP SHALL last exactly GAP_CYC cycles, then go to DWELL of the next digit.
REQ-017 The digit index SHALL increment modulo 4 (3 wraps to 0); a full frame is 4*(DWELL_CYC+GAP_CYC) cycles.
REQ-018 The frame boundary is the last cycle before digit 3 hands over to digit 0. On that cycle, frame_done=1.
REQ-019 On the frame boundary, if the shadow register is full, shadow SHALL copy to active and the shadow SHALL be marked empty; blank_lz SHALL be sampled.
REQ-020 The new value SHALL appear on digit 0 in the very next cycle; the active value SHALL never change mid-frame.
REQ-021 load_ready SHALL equal NOT shadow_full. A transfer occurs on a cycle with load_valid=1 and load_ready=1, and SHALL write load_data to the shadow and set shadow_full.
REQ-022 On a frame-boundary cycle with the shadow empty and a transfer accepted, the data SHALL go to the shadow and be promoted at the following boundary.
REQ-023 load_valid while load_ready=0 SHALL be ignored; the shadow is never overwritten.
REQ-024 Leading-zero blanking, when the sampled blank_lz=1, SHALL blank every digit more significant than the highest nonzero nibble. Digit 0 is never blanked, so value 0 shows a single "0".
REQ-025 sel, seg and frame_done SHALL be registered outputs, with no combinational path from inputs.
REQ-026 Hex decode (0-F, active-low) SHALL be patterns: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E.

Reset
REQ-027 While rst=1, the outputs SHALL be: sel=4'hF, seg=7'h7F, frame_done=0, load_ready=1.
REQ-028 While rst=1, the internal state SHALL be: active=16'h0000, shadow empty, blank_lz latch=0, state=DWELL, digit index=0, counter=0.
REQ-029 After rst falls, the first DWELL of digit 0 SHALL drive sel=4'hE, seg=7'h40 within one cycle.
REQ-030 Reset mid-frame or mid-handshake SHALL discard the shadow and active values with no partial update.

Structure
REQ-031 The segment patterns, blank code 7'h7F, all-off code 4'hF and the state encoding SHALL live in the shared package seg_pkg.
REQ-032 The combinational hex-to-segment decoder SHALL be the sub-module seg7_dec (4-bit in, 7-bit out), instantiated once.

Verification (DWELL_CYC=4, GAP_CYC=1)
REQ-033 Reset then free-run: sel SHALL cycle E,F,D,F,B,F,7,F with 4 cycles per digit and 1 cycle per gap; frame_done SHALL pulse every 20 cycles; seg SHALL be 40 on each digit.
REQ-034 Load 16'h12AF mid-frame: it SHALL be accepted in 1 cycle, load_ready SHALL then be 0, and the display SHALL stay 0000 until the boundary. The next frame SHALL show seg F=0E, A=08, 2=24, 1=79 on digits 0..3, and load_ready SHALL return to 1 at the boundary.
REQ-035 Two back-to-back loads (16'h1111, then 16'h2222 held valid): the second SHALL stall until the boundary. The frames SHALL show 1111, then 2222; the second load SHALL not be lost or overwritten.
REQ-036 blank_lz=1 with 16'h0050: digits 3 and 2 SHALL show 7F, digit 1 SHALL show 12, digit 0 SHALL show 40. With 16'h0000, only digit 0 SHALL show 40.
REQ-037 Load accepted on the exact boundary cycle: the value SHALL be displayed one full frame later.
REQ-038 Assert rst during digit 2 with a pending shadow: the next cycle SHALL have sel=F, seg=7F, load_ready=1; after release the display SHALL show 0000 and the shadow SHALL be discarded.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: FSM encoding,
// active-low segment patterns and the leading-digit helper.
package seg_pkg;

    typedef enum logic {
        ST_DWELL = 1'b0,
        ST_GAP   = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] SEL_OFF   = 4'hF;

    // Active-low patterns, segment g in bit 6 down to segment a in bit 0
    localparam logic [6:0] SEG_PAT [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Index of the most significant nonzero nibble; 0 when the value is zero
    function automatic logic [1:0] top_digit(input logic [15:0] v);
        logic [1:0] m;
        m = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (v[4*i +: 4] != 4'h0) begin
                m = 2'(i);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg7_dec
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_PAT[i_nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a shadow/active display
// register pair that only swaps at the frame boundary.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DWELL_CYC = 12500,
    parameter int GAP_CYC   = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    input  logic        blank_lz,
    output logic [3:0]  sel,
    output logic [6:0]  seg,
    output logic        frame_done
);

    localparam int MAX_CYC = (DWELL_CYC > GAP_CYC) ? DWELL_CYC : GAP_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

    scan_state_t      r_state;
    logic [1:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_run;
    logic [15:0]      r_active;
    logic [15:0]      r_shadow;
    logic             r_shadow_full;
    logic             r_blank;
    logic [3:0]       r_sel;
    logic [6:0]       r_seg;
    logic             r_frame_done;

    scan_state_t      w_nxt_state;
    logic [1:0]       w_nxt_idx;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic             w_bnd;
    logic             w_nxt_bnd;
    logic [15:0]      w_nxt_active;
    logic             w_nxt_blank;
    logic             w_take;
    logic [3:0]       w_dec_nib;
    logic [6:0]       w_dec_seg;
    logic [3:0]       w_nxt_sel;
    logic [6:0]       w_nxt_seg;

    // True on the final cycle of digit 3, i.e. the cycle before digit 0 starts
    function automatic logic is_last(input scan_state_t st, input logic [1:0] idx,
                                     input logic [CNT_W-1:0] cnt);
        logic gap_end;
        logic dwell_end;
        gap_end   = (st == ST_GAP) && (cnt == GAP_LAST);
        dwell_end = (st == ST_DWELL) && (GAP_CYC == 0) && (cnt == DWELL_LAST);
        return (idx == 2'd3) && (gap_end || dwell_end);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_DWELL;
            r_idx   <= 2'd0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_idx   <= w_nxt_idx;
            r_cnt   <= w_nxt_cnt;
            r_run   <= 1'b1;
        end
    end

    // The first cycle out of reset holds position so digit 0 gets a full dwell
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_cnt   = r_cnt;
        if (r_run) begin
            case (r_state)
                ST_DWELL: begin
                    if (r_cnt == DWELL_LAST) begin
                        w_nxt_cnt = '0;
                        if (GAP_CYC == 0) begin
                            w_nxt_idx = r_idx + 2'd1;
                        end else begin
                            w_nxt_state = ST_GAP;
                        end
                    end else begin
                        w_nxt_cnt = r_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        w_nxt_state = ST_DWELL;
                        w_nxt_idx   = r_idx + 2'd1;
                        w_nxt_cnt   = '0;
                    end else begin
                        w_nxt_cnt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_nxt_state = ST_DWELL;
                    w_nxt_cnt   = '0;
                end
            endcase
        end
    end

    assign w_bnd        = r_run && is_last(r_state, r_idx, r_cnt);
    assign w_nxt_bnd    = is_last(w_nxt_state, w_nxt_idx, w_nxt_cnt);
    assign w_nxt_active = (w_bnd && r_shadow_full) ? r_shadow : r_active;
    assign w_nxt_blank  = w_bnd ? blank_lz : r_blank;
    assign w_take       = load_valid && !r_shadow_full;
    assign w_dec_nib    = w_nxt_active[{w_nxt_idx, 2'b00} +: 4];

    // Shadow accepts only when empty, so a promotion and a write never collide
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active      <= 16'h0000;
            r_shadow      <= 16'h0000;
            r_shadow_full <= 1'b0;
            r_blank       <= 1'b0;
        end else begin
            r_active <= w_nxt_active;
            r_blank  <= w_nxt_blank;
            if (w_take) begin
                r_shadow      <= load_data;
                r_shadow_full <= 1'b1;
            end else if (w_bnd && r_shadow_full) begin
                r_shadow_full <= 1'b0;
            end
        end
    end

    seg7_dec u_dec (
        .i_nib (w_dec_nib),
        .o_seg (w_dec_seg)
    );

    // Outputs are decoded from the next state so the registers line up with it
    always_comb begin
        w_nxt_sel = SEL_OFF;
        w_nxt_seg = SEG_BLANK;
        if (w_nxt_state == ST_DWELL) begin
            w_nxt_sel = ~(4'b0001 << w_nxt_idx);
            if (!(w_nxt_blank && (w_nxt_idx > top_digit(w_nxt_active)))) begin
                w_nxt_seg = w_dec_seg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel        <= SEL_OFF;
            r_seg        <= SEG_BLANK;
            r_frame_done <= 1'b0;
        end else begin
            r_sel        <= w_nxt_sel;
            r_seg        <= w_nxt_seg;
            r_frame_done <= w_nxt_bnd;
        end
    end

    assign sel        = r_sel;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;
    assign load_ready = !r_shadow_full;

endmodule
